// File: rtl/lsu_sram_if.sv
// Request/response bundle between the LSU (master) and its data memory (slave).
// Requests are single-cycle pulses; responses are single-cycle pulses.
interface lsu_sram_if;
  logic        req_valid;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        req_drop;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  resp_valid, resp_rdata, resp_err, req_drop
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output resp_valid, resp_rdata, resp_err, req_drop
  );
endinterface

// File: rtl/lsu_sram.sv
// Data-memory responder for the LSU: holds each request for a fixed or LFSR-randomised
// latency, then performs a byte-masked store or word load and pulses a response.
module lsu_sram #(
  parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
  parameter int          DEPTH_WORDS   = 4096,
  parameter int          LAT_MIN       = 1,
  parameter int          LAT_RAND_BITS = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  lsu_sram_if.slave  bus
);
  localparam int LAT_MAX = LAT_MIN + (1 << LAT_RAND_BITS) - 1;
  localparam int CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
  localparam int IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             wen_q, wen_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       wmask_q, wmask_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             rdata_ok_q, rdata_ok_d;
  logic             drop_q, drop_d;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rd_word_q;

  logic [CNT_W-1:0] lat_m1;
  logic             acc_wen;
  logic [31:0]      acc_addr, acc_wdata, acc_off;
  logic [3:0]       acc_wmask;
  logic             acc_fire, acc_in_range;
  logic [IDX_W-1:0] acc_idx;
  logic             unused_bits;

  generate
    if (LAT_RAND_BITS > 0) begin : g_rand_lat
      assign lat_m1 = CNT_W'(LAT_MIN - 1) + CNT_W'(lfsr_q[LAT_RAND_BITS-1:0]);
    end else begin : g_fixed_lat
      assign lat_m1 = CNT_W'(LAT_MIN - 1);
    end
  endgenerate

  // With a one-cycle latency the access happens on the request edge itself,
  // so the operands come straight off the bus instead of the captured copies.
  always_comb begin
    acc_wen   = (state_q == IDLE) ? bus.req_wen   : wen_q;
    acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
    acc_wmask = (state_q == IDLE) ? bus.req_wmask : wmask_q;
  end

  // Addresses below the base wrap to huge offsets, so one unsigned compare covers both ends.
  assign acc_off      = acc_addr - ADDR_BASE;
  assign acc_in_range = ({1'b0, acc_off} < SPAN);
  assign acc_idx      = acc_off[IDX_W+1:2];
  assign unused_bits  = ^{acc_off[1:0], acc_off[31:IDX_W+2]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    wen_d        = wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    rdata_ok_d   = rdata_ok_q;
    drop_d       = drop_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          wen_d   = bus.req_wen;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wmask_d = bus.req_wmask;
          cnt_d   = lat_m1;
          state_d = (lat_m1 == '0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (bus.req_valid) drop_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = RESP;
      end
      RESP: begin
        if (bus.req_valid) drop_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == RESP) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !acc_in_range;
      rdata_ok_d   = acc_in_range && !acc_wen;
    end
  end

  assign acc_fire = (state_d == RESP) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lfsr_q       <= LFSR_SEED;
      wen_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_ok_q   <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      wen_q        <= wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_ok_q   <= rdata_ok_d;
      drop_q       <= drop_d;
    end
  end

  // Array port kept free of reset so it maps onto block RAM with a registered read.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_in_range) begin
      if (acc_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (acc_wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end else begin
        rd_word_q <= mem[acc_idx];
      end
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = rdata_ok_q ? rd_word_q : 32'h0;
  assign bus.req_drop   = drop_q;
endmodule

// File: tb/tb_lsu_sram.sv
// Directed bench for lsu_sram: a fixed-latency instance and a random-latency instance.
module tb_lsu_sram;
  logic clk = 1'b0;
  logic rst_f = 1'b1;
  logic rst_r = 1'b1;
  always #5 clk = ~clk;

  lsu_sram_if bus_f ();
  lsu_sram_if bus_r ();

  lsu_sram #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(4096), .LAT_MIN(1),
             .LAT_RAND_BITS(0), .LFSR_SEED(16'hACE1))
    u_fix (.clk(clk), .rst(rst_f), .bus(bus_f));

  lsu_sram #(.ADDR_BASE(32'h8000_0000), .DEPTH_WORDS(4096), .LAT_MIN(2),
             .LAT_RAND_BITS(2), .LFSR_SEED(16'hACE1))
    u_rnd (.clk(clk), .rst(rst_r), .bus(bus_r));

  int checks = 0;
  int errors = 0;
  int resp_cnt_f = 0;
  int resp_cnt_r = 0;
  logic [31:0] sb [16];

  always @(negedge clk) begin
    if (bus_f.resp_valid === 1'b1) resp_cnt_f <= resp_cnt_f + 1;
    if (bus_r.resp_valid === 1'b1) resp_cnt_r <= resp_cnt_r + 1;
  end

  task automatic drive(input bit sel, input logic v, input logic wen, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m);
    if (sel) begin
      bus_r.req_valid = v; bus_r.req_wen = wen; bus_r.req_addr = a;
      bus_r.req_wdata = d; bus_r.req_wmask = m;
    end else begin
      bus_f.req_valid = v; bus_f.req_wen = wen; bus_f.req_addr = a;
      bus_f.req_wdata = d; bus_f.req_wmask = m;
    end
  endtask

  function automatic logic resp_v(input bit sel);
    return sel ? bus_r.resp_valid : bus_f.resp_valid;
  endfunction

  // Issues one request in an idle cycle, scrambles the bus afterwards, and waits for the
  // response; lat is the cycle count from request to response (-1 on timeout).
  task automatic do_req(input bit sel, input logic wen, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, output int lat, output logic [31:0] rdata,
                        output logic err);
    @(negedge clk);
    drive(sel, 1'b1, wen, a, d, m);
    @(negedge clk);
    drive(sel, 1'b0, ~wen, ~a, ~d, ~m);
    lat = 1;
    while (resp_v(sel) !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) lat = -1;
    rdata = sel ? bus_r.resp_rdata : bus_f.resp_rdata;
    err   = sel ? bus_r.resp_err : bus_f.resp_err;
    $display("req sel=%0d wen=%0b addr=%h wdata=%h mask=%b -> lat=%0d rdata=%h err=%0b",
             sel, wen, a, d, m, lat, rdata, err);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_f.resp_valid, bus_f.resp_err, bus_f.req_drop} !== 3'b000 || bus_f.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_in_reset: got v=%b err=%b drop=%b rdata=%h, expected 0 0 0 00000000",
               bus_f.resp_valid, bus_f.resp_err, bus_f.req_drop, bus_f.resp_rdata);
    end
    rst_f = 1'b0;
    rst_r = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_f.resp_valid, bus_f.resp_err, bus_f.req_drop} !== 3'b000 || bus_f.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_fix: got v=%b err=%b drop=%b rdata=%h, expected 0 0 0 00000000",
               bus_f.resp_valid, bus_f.resp_err, bus_f.req_drop, bus_f.resp_rdata);
    end
    checks++;
    if ({bus_r.resp_valid, bus_r.resp_err, bus_r.req_drop} !== 3'b000 || bus_r.resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_rnd: got v=%b err=%b drop=%b rdata=%h, expected 0 0 0 00000000",
               bus_r.resp_valid, bus_r.resp_err, bus_r.req_drop, bus_r.resp_rdata);
    end
  endtask

  task automatic test_fixed_latency();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, lat, rd, err);
    checks++;
    if (lat !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL fixed_store: got lat=%0d err=%b, expected lat=1 err=0", lat, err);
    end
    do_req(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (lat !== 1 || err !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL fixed_load: got lat=%0d err=%b rdata=%h, expected lat=1 err=0 rdata=deadbeef",
               lat, err, rd);
    end
  endtask

  task automatic test_byte_mask();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, lat, rd, err);
    do_req(1'b0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (rd !== 32'hDE22_BE44 || err !== 1'b0) begin
      errors++;
      $display("FAIL mask_0101: got rdata=%h err=%b, expected de22be44 err=0", rd, err);
    end
    do_req(1'b0, 1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0000, lat, rd, err);
    do_req(1'b0, 1'b0, 32'h8000_0012, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (rd !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL mask_0000: got rdata=%h, expected de22be44", rd);
    end
  endtask

  task automatic test_range_err();
    int lat; logic [31:0] rd; logic err;
    do_req(1'b0, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat !== 1) begin
      errors++;
      $display("FAIL range_below: got err=%b rdata=%h lat=%0d, expected err=1 rdata=0 lat=1", err, rd, lat);
    end
    do_req(1'b0, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, lat, rd, err);
    do_req(1'b0, 1'b1, 32'h8000_4000, 32'h0BAD_0BAD, 4'hF, lat, rd, err);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL range_above_store: got err=%b, expected 1", err);
    end
    do_req(1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (err !== 1'b0 || rd !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL range_word0: got err=%b rdata=%h, expected err=0 rdata=cafef00d", err, rd);
    end
    do_req(1'b0, 1'b1, 32'h8000_3FFC, 32'h600D_CAFE, 4'hF, lat, rd, err);
    do_req(1'b0, 1'b0, 32'h8000_3FFC, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (err !== 1'b0 || rd !== 32'h600D_CAFE) begin
      errors++;
      $display("FAIL range_last_word: got err=%b rdata=%h, expected err=0 rdata=600dcafe", err, rd);
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd; logic err;
    int seen [6];
    int n0;
    logic wen; logic [31:0] d; logic [3:0] m; int idx;
    for (int k = 0; k < 6; k++) seen[k] = 0;
    n0 = resp_cnt_r;
    for (int i = 0; i < 1000; i++) begin
      if (i < 16) begin
        wen = 1'b1; idx = i; m = 4'hF;
      end else begin
        wen = 1'($urandom_range(0, 1)); idx = $urandom_range(0, 15); m = 4'($urandom_range(0, 15));
      end
      d = $urandom;
      do_req(1'b1, wen, 32'h8000_0100 + 32'(idx * 4) + 32'($urandom_range(0, 3)), d, m, lat, rd, err);
      checks++;
      if (lat < 2 || lat > 5 || err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got lat=%0d err=%b, expected lat in 2..5 err=0", i, lat, err);
      end else begin
        seen[lat]++;
      end
      if (wen) begin
        for (int b = 0; b < 4; b++) if (m[b]) sb[idx][8*b +: 8] = d[8*b +: 8];
      end else begin
        checks++;
        if (rd !== sb[idx]) begin
          errors++;
          $display("FAIL b2b_rdata[%0d]: got %h, expected %h", i, rd, sb[idx]);
        end
      end
    end
    repeat (3) @(negedge clk);
    for (int k = 2; k <= 5; k++) begin
      checks++;
      if (seen[k] == 0) begin
        errors++;
        $display("FAIL b2b_lat_coverage: latency %0d seen 0 times, expected at least 1", k);
      end
    end
    checks++;
    if (resp_cnt_r - n0 != 1000 || bus_r.req_drop !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp_count: got %0d responses drop=%b, expected 1000 drop=0",
               resp_cnt_r - n0, bus_r.req_drop);
    end
  endtask

  task automatic test_drop();
    int lat; logic [31:0] rd; logic err; int n0;
    n0 = resp_cnt_r;
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0104, 32'h5555_5555, 4'hF);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (10) @(negedge clk);
    $display("drop pulse: responses=%0d drop=%b", resp_cnt_r - n0, bus_r.req_drop);
    checks++;
    if (resp_cnt_r - n0 != 1 || bus_r.req_drop !== 1'b1) begin
      errors++;
      $display("FAIL drop_busy: got %0d responses drop=%b, expected 1 drop=1", resp_cnt_r - n0, bus_r.req_drop);
    end
    do_req(1'b1, 1'b0, 32'h8000_0104, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (rd !== sb[1] || bus_r.req_drop !== 1'b1 || bus_f.req_drop !== 1'b0) begin
      errors++;
      $display("FAIL drop_sticky: got rdata=%h drop_r=%b drop_f=%b, expected rdata=%h drop_r=1 drop_f=0",
               rd, bus_r.req_drop, bus_f.req_drop, sb[1]);
    end
  endtask

  task automatic test_reset_mid_op();
    int lat; logic [31:0] rd; logic err; int n0;
    do_req(1'b1, 1'b1, 32'h8000_0020, 32'h1234_5678, 4'hF, lat, rd, err);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst_r = 1'b1;
    #1;
    checks++;
    if (bus_r.resp_valid !== 1'b0 || bus_r.req_drop !== 1'b0) begin
      errors++;
      $display("FAIL midop_async_clear: got v=%b drop=%b, expected 0 0", bus_r.resp_valid, bus_r.req_drop);
    end
    repeat (2) @(negedge clk);
    rst_r = 1'b0;
    n0 = resp_cnt_r;
    repeat (10) @(negedge clk);
    checks++;
    if (resp_cnt_r != n0) begin
      errors++;
      $display("FAIL midop_no_resp: got %0d responses after release, expected 0", resp_cnt_r - n0);
    end
    do_req(1'b1, 1'b0, 32'h8000_0020, 32'h0, 4'h0, lat, rd, err);
    checks++;
    if (rd !== 32'h1234_5678 || err !== 1'b0) begin
      errors++;
      $display("FAIL midop_not_written: got rdata=%h err=%b, expected 12345678 err=0", rd, err);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_fixed_latency();
    test_byte_mask();
    test_range_err();
    test_back_to_back();
    test_drop();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
